// File: rtl/leiwand_rv32_wb_arbiter_pkg.sv
// Shared constants for the leiwand rv32 Wishbone arbiter: bus width,
// arbiter FSM encodings and a counter sizing helper.
package leiwand_rv32_wb_arbiter_pkg;

    localparam int MEM_WIDTH = 32;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_GRANT0 = 2'd1;
    localparam logic [1:0] ARB_GRANT1 = 2'd2;

    // Index of the highest bit needed to hold value (never below 0).
    function automatic int HIGH_BIT_TO_FIT(input int value);
        if (value <= 1) begin
            return 0;
        end
        return $clog2(value + 1) - 1;
    endfunction

endpackage

// File: rtl/leiwand_rv32_wb_timeout.sv
// Saturating ack-timeout counter; o_expired is high in the cycle the count
// sits at TIMEOUT_CYCLES while enabled and not being cleared.
module leiwand_rv32_wb_timeout
    import leiwand_rv32_wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int               CNT_W = HIGH_BIT_TO_FIT(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // A limit of zero means the timeout is disabled altogether.
    assign o_expired = (TIMEOUT_CYCLES != 0) && i_enable && !i_clear && (r_count == LIMIT);

endmodule

// File: rtl/leiwand_rv32_wb_arbiter.sv
// Two-master pipelined Wishbone arbiter: round-robin, grant held for a whole
// cyc, with an ack timeout that errors out a master whose slave is silent.
module leiwand_rv32_wb_arbiter
    import leiwand_rv32_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = MEM_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    input  logic                  i_m0_cyc,
    input  logic                  i_m0_stb,
    input  logic                  i_m0_we,
    input  logic [DATA_WIDTH-1:0] i_m0_addr,
    input  logic [DATA_WIDTH-1:0] i_m0_data,
    output logic                  o_m0_ack,
    output logic                  o_m0_stall,
    output logic                  o_m0_err,
    output logic [DATA_WIDTH-1:0] o_m0_data,

    input  logic                  i_m1_cyc,
    input  logic                  i_m1_stb,
    input  logic                  i_m1_we,
    input  logic [DATA_WIDTH-1:0] i_m1_addr,
    input  logic [DATA_WIDTH-1:0] i_m1_data,
    output logic                  o_m1_ack,
    output logic                  o_m1_stall,
    output logic                  o_m1_err,
    output logic [DATA_WIDTH-1:0] o_m1_data,

    output logic                  o_cyc,
    output logic                  o_stb,
    output logic                  o_we,
    output logic [DATA_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ack,
    input  logic                  i_stall,
    input  logic [DATA_WIDTH-1:0] i_data
);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_last;
    logic       w_idle;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_expired;

    assign w_idle   = (r_state == ARB_IDLE);
    assign w_grant0 = (r_state == ARB_GRANT0);
    assign w_grant1 = (r_state == ARB_GRANT1);

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    w_next_state = r_last ? ARB_GRANT0 : ARB_GRANT1;
                end else if (i_m0_cyc) begin
                    w_next_state = ARB_GRANT0;
                end else if (i_m1_cyc) begin
                    w_next_state = ARB_GRANT1;
                end
            end
            ARB_GRANT0: begin
                if (!i_m0_cyc || w_expired) begin
                    w_next_state = ARB_IDLE;
                end
            end
            ARB_GRANT1: begin
                if (!i_m1_cyc || w_expired) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ARB_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_idle && (w_next_state != ARB_IDLE)) begin
                r_last <= (w_next_state == ARB_GRANT1);
            end
        end
    end

    // Held clear while idle, so every new grant starts from zero.
    leiwand_rv32_wb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_idle || i_ack),
        .i_enable  (!w_idle),
        .o_expired (w_expired)
    );

    always_comb begin
        o_cyc  = 1'b0;
        o_stb  = 1'b0;
        o_we   = 1'b0;
        o_addr = '0;
        o_data = '0;
        if (w_grant0) begin
            o_cyc  = i_m0_cyc;
            o_stb  = i_m0_stb;
            o_we   = i_m0_we;
            o_addr = i_m0_addr;
            o_data = i_m0_data;
        end else if (w_grant1) begin
            o_cyc  = i_m1_cyc;
            o_stb  = i_m1_stb;
            o_we   = i_m1_we;
            o_addr = i_m1_addr;
            o_data = i_m1_data;
        end
        if (w_expired) begin
            o_cyc = 1'b0;
            o_stb = 1'b0;
        end
    end

    assign o_m0_stall = w_grant0 ? i_stall : 1'b1;
    assign o_m1_stall = w_grant1 ? i_stall : 1'b1;
    assign o_m0_ack   = w_grant0 && i_ack && !w_expired;
    assign o_m1_ack   = w_grant1 && i_ack && !w_expired;
    assign o_m0_err   = w_grant0 && w_expired;
    assign o_m1_err   = w_grant1 && w_expired;
    assign o_m0_data  = i_data;
    assign o_m1_data  = i_data;

endmodule

// File: tb/tb_leiwand_rv32_wb_arbiter.sv
// Directed bench for leiwand_rv32_wb_arbiter: three instances share stimulus
// (timeouts 255, 8 and 0); each test checks the instance it targets.
module tb_leiwand_rv32_wb_arbiter;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;

    logic          m0_cyc, m0_stb, m0_we;
    logic [DW-1:0] m0_addr, m0_wdata;
    logic          m1_cyc, m1_stb, m1_we;
    logic [DW-1:0] m1_addr, m1_wdata;
    logic          ack, stall;
    logic [DW-1:0] sdata;

    logic [2:0]    m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err;
    logic [2:0]    s_cyc, s_stb, s_we;
    logic [DW-1:0] m0_rdata [3];
    logic [DW-1:0] m1_rdata [3];
    logic [DW-1:0] s_addr   [3];
    logic [DW-1:0] s_wdata  [3];

    int checks = 0;
    int errors = 0;

    // Burst script: beat presented, slave stall and slave ack per granted cycle.
    int            burst_beat  [6] = '{0, 1, 1, 2, 3, -1};
    bit            burst_stall [6] = '{0, 1, 0, 0, 0, 0};
    bit            burst_ack   [6] = '{0, 1, 0, 1, 1, 1};
    logic [DW-1:0] burst_addr  [4] = '{32'h2000_0000, 32'h2000_0004, 32'h2000_0008, 32'h2000_000C};
    logic [DW-1:0] burst_data  [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        leiwand_rv32_wb_arbiter #(
            .DATA_WIDTH     (DW),
            .TIMEOUT_CYCLES (g == 0 ? 255 : (g == 1 ? 8 : 0))
        ) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_m0_cyc   (m0_cyc),
            .i_m0_stb   (m0_stb),
            .i_m0_we    (m0_we),
            .i_m0_addr  (m0_addr),
            .i_m0_data  (m0_wdata),
            .o_m0_ack   (m0_ack[g]),
            .o_m0_stall (m0_stall[g]),
            .o_m0_err   (m0_err[g]),
            .o_m0_data  (m0_rdata[g]),
            .i_m1_cyc   (m1_cyc),
            .i_m1_stb   (m1_stb),
            .i_m1_we    (m1_we),
            .i_m1_addr  (m1_addr),
            .i_m1_data  (m1_wdata),
            .o_m1_ack   (m1_ack[g]),
            .o_m1_stall (m1_stall[g]),
            .o_m1_err   (m1_err[g]),
            .o_m1_data  (m1_rdata[g]),
            .o_cyc      (s_cyc[g]),
            .o_stb      (s_stb[g]),
            .o_we       (s_we[g]),
            .o_addr     (s_addr[g]),
            .o_data     (s_wdata[g]),
            .i_ack      (ack),
            .i_stall    (stall),
            .i_data     (sdata)
        );
    end

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_m(input int m, input logic cyc, input logic stb);
        if (m == 0) begin
            m0_cyc = cyc;
            m0_stb = stb;
        end else begin
            m1_cyc = cyc;
            m1_stb = stb;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_addr = 32'h1000_0000; m0_wdata = 32'h0;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_addr = 32'h2000_0000; m1_wdata = 32'h5555_AAAA;
        ack = 1'b0; stall = 1'b0; sdata = '0;
        tick(); tick(); #1;
        checks++; if ({s_cyc[0], s_stb[0], s_we[0]} !== 3'b000) begin
            errors++; $display("FAIL reset_cyc_stb_we: got %b expected 000", {s_cyc[0], s_stb[0], s_we[0]}); end
        checks++; if (s_addr[0] !== 32'h0) begin
            errors++; $display("FAIL reset_addr: got %h expected 00000000", s_addr[0]); end
        checks++; if (s_wdata[0] !== 32'h0) begin
            errors++; $display("FAIL reset_wdata: got %h expected 00000000", s_wdata[0]); end
        checks++; if ({m0_stall[0], m1_stall[0]} !== 2'b11) begin
            errors++; $display("FAIL reset_stalls: got %b expected 11", {m0_stall[0], m1_stall[0]}); end
        checks++; if ({m0_ack[0], m1_ack[0], m0_err[0], m1_err[0]} !== 4'b0000) begin
            errors++; $display("FAIL reset_ack_err: got %b expected 0000", {m0_ack[0], m1_ack[0], m0_err[0], m1_err[0]}); end
        rst_n = 1'b1;
        tick(); #1;
        checks++; if (s_addr[0] !== 32'h1000_0000) begin
            errors++; $display("FAIL first_grant_addr: got %h expected 10000000", s_addr[0]); end
        checks++; if ({s_cyc[0], m0_stall[0], m1_stall[0]} !== 3'b101) begin
            errors++; $display("FAIL first_grant_cyc_stalls: got %b expected 101", {s_cyc[0], m0_stall[0], m1_stall[0]}); end
        drive_m(0, 1'b0, 1'b0);
        drive_m(1, 1'b0, 1'b0);
        tick(); #1;
        checks++; if (m0_stall[0] !== 1'b1) begin
            errors++; $display("FAIL release_idle_stall: got %b expected 1", m0_stall[0]); end
    endtask

    task automatic test_single_read();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0100;
        #1;
        checks++; if (m0_stall[0] !== 1'b1) begin
            errors++; $display("FAIL read_pre_grant_stall: got %b expected 1", m0_stall[0]); end
        tick(); #1;
        checks++; if ({s_stb[0], m0_stall[0]} !== 2'b10 || s_addr[0] !== 32'h0000_0100) begin
            errors++; $display("FAIL read_stb: got stb/stall %b addr %h expected 10 addr 00000100", {s_stb[0], m0_stall[0]}, s_addr[0]); end
        tick(); m0_stb = 1'b0; #1;
        checks++; if (m0_ack[0] !== 1'b0) begin
            errors++; $display("FAIL read_early_ack: got %b expected 0", m0_ack[0]); end
        tick(); ack = 1'b1; sdata = 32'hDEAD_BEEF; #1;
        checks++; if ({m0_ack[0], m1_ack[0]} !== 2'b10) begin
            errors++; $display("FAIL read_ack: got %b expected 10", {m0_ack[0], m1_ack[0]}); end
        checks++; if (m0_rdata[0] !== 32'hDEAD_BEEF || m1_rdata[0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL read_data: got %h/%h expected deadbeef", m0_rdata[0], m1_rdata[0]); end
        tick(); ack = 1'b0; m0_cyc = 1'b0; #1;
        checks++; if ({m0_ack[0], s_cyc[0]} !== 2'b00) begin
            errors++; $display("FAIL read_ack_single_cycle: got %b expected 00", {m0_ack[0], s_cyc[0]}); end
        tick(); #1;
        checks++; if (m0_stall[0] !== 1'b1) begin
            errors++; $display("FAIL read_back_to_idle: got %b expected 1", m0_stall[0]); end
    endtask

    task automatic test_alternation();
        int exp_m;
        exp_m = 1;
        m0_addr = 32'h3000_0000; m1_addr = 32'h4000_0000; m1_we = 1'b0;
        drive_m(0, 1'b1, 1'b1);
        drive_m(1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            checks++; if (s_addr[0] !== (exp_m == 1 ? 32'h4000_0000 : 32'h3000_0000)
                          || {m0_stall[0], m1_stall[0]} !== (exp_m == 1 ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL alt_grant[%0d]: got addr %h stalls %b expected master %0d", i, s_addr[0], {m0_stall[0], m1_stall[0]}, exp_m); end
            tick(); drive_m(exp_m, 1'b1, 1'b0); ack = 1'b1; #1;
            checks++; if ({m0_ack[0], m1_ack[0]} !== (exp_m == 1 ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL alt_ack[%0d]: got %b expected master %0d", i, {m0_ack[0], m1_ack[0]}, exp_m); end
            tick(); ack = 1'b0; drive_m(exp_m, 1'b0, 1'b0); #1;
            tick();
            if (i < 3) drive_m(exp_m, 1'b1, 1'b1);
            else       drive_m(1 - exp_m, 1'b0, 1'b0);
            #1;
            checks++; if ({s_cyc[0], m0_stall[0], m1_stall[0]} !== 3'b011) begin
                errors++; $display("FAIL alt_dead_cycle[%0d]: got %b expected 011", i, {s_cyc[0], m0_stall[0], m1_stall[0]}); end
            exp_m = 1 - exp_m;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        m0_addr = 32'h5000_0000;
        drive_m(0, 1'b1, 1'b1);
        tick(); #1;
        checks++; if (s_cyc[0] !== 1'b1 || s_addr[0] !== 32'h5000_0000) begin
            errors++; $display("FAIL b2b_first_grant: got cyc %b addr %h expected 1 50000000", s_cyc[0], s_addr[0]); end
        tick(); drive_m(0, 1'b0, 1'b0);
        tick(); drive_m(0, 1'b1, 1'b1); ack = 1'b1; #1;
        checks++; if ({s_cyc[0], m0_stall[0], m0_ack[0]} !== 3'b010) begin
            errors++; $display("FAIL b2b_dead_cycle_idle_ack: got %b expected 010", {s_cyc[0], m0_stall[0], m0_ack[0]}); end
        tick(); ack = 1'b0; #1;
        checks++; if ({s_cyc[0], m0_stall[0]} !== 2'b10) begin
            errors++; $display("FAIL b2b_regrant: got %b expected 10", {s_cyc[0], m0_stall[0]}); end
        tick(); drive_m(0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_burst();
        int n_acks;
        n_acks = 0;
        m0_addr = 32'h6000_0000; m0_we = 1'b0;
        drive_m(0, 1'b1, 1'b1);
        m1_we = 1'b1; m1_addr = burst_addr[0]; m1_wdata = burst_data[0];
        drive_m(1, 1'b1, 1'b1);
        for (int c = 0; c < 6; c++) begin
            tick();
            if (burst_beat[c] >= 0) begin
                m1_stb = 1'b1; m1_addr = burst_addr[burst_beat[c]]; m1_wdata = burst_data[burst_beat[c]];
            end else begin
                m1_stb = 1'b0;
            end
            stall = burst_stall[c]; ack = burst_ack[c];
            #1;
            checks++; if ({m1_stall[0], m1_ack[0]} !== {burst_stall[c], burst_ack[c]}) begin
                errors++; $display("FAIL burst_m1_resp[%0d]: got stall/ack %b expected %b", c, {m1_stall[0], m1_ack[0]}, {burst_stall[c], burst_ack[c]}); end
            checks++; if ({m0_stall[0], m0_ack[0]} !== 2'b10) begin
                errors++; $display("FAIL burst_m0_blocked[%0d]: got %b expected 10", c, {m0_stall[0], m0_ack[0]}); end
            if (burst_beat[c] >= 0) begin
                checks++; if ({s_stb[0], s_we[0]} !== 2'b11 || s_addr[0] !== burst_addr[burst_beat[c]]
                              || s_wdata[0] !== burst_data[burst_beat[c]]) begin
                    errors++; $display("FAIL burst_beat[%0d]: got stb/we %b addr %h data %h", c, {s_stb[0], s_we[0]}, s_addr[0], s_wdata[0]); end
            end
            if (m1_ack[0] === 1'b1) n_acks++;
        end
        checks++; if (n_acks != 4) begin
            errors++; $display("FAIL burst_ack_count: got %0d expected 4", n_acks); end
        tick(); stall = 1'b0; ack = 1'b0; drive_m(1, 1'b0, 1'b0); #1;
        checks++; if (m0_stall[0] !== 1'b1) begin
            errors++; $display("FAIL burst_m0_stall_at_release: got %b expected 1", m0_stall[0]); end
        drive_m(0, 1'b0, 1'b0);
        tick(); tick();
    endtask

    task automatic test_timeout();
        logic exp_err;
        m0_addr = 32'h7000_0000; m0_we = 1'b0;
        drive_m(0, 1'b1, 1'b1);
        for (int k = 0; k <= 8; k++) begin
            tick();
            if (k >= 1) m0_stb = 1'b0;
            #1;
            exp_err = (k == 8);
            checks++; if ({m0_err[1], s_cyc[1], m0_ack[1]} !== {exp_err, ~exp_err, 1'b0}) begin
                errors++; $display("FAIL timeout_cycle[%0d]: got err/cyc/ack %b expected %b", k, {m0_err[1], s_cyc[1], m0_ack[1]}, {exp_err, ~exp_err, 1'b0}); end
        end
        tick(); drive_m(0, 1'b0, 1'b0); #1;
        checks++; if ({m0_stall[1], m0_err[1]} !== 2'b10) begin
            errors++; $display("FAIL timeout_to_idle: got stall/err %b expected 10", {m0_stall[1], m0_err[1]}); end
        tick();
    endtask

    task automatic test_ack_wins();
        drive_m(0, 1'b1, 1'b1);
        for (int k = 0; k <= 9; k++) begin
            tick();
            if (k >= 1) m0_stb = 1'b0;
            ack = (k == 8);
            #1;
            checks++; if ({m0_err[1], s_cyc[1], m0_stall[1], m0_ack[1]} !== {3'b010, (k == 8)}) begin
                errors++; $display("FAIL ack_wins[%0d]: got err/cyc/stall/ack %b expected %b", k, {m0_err[1], s_cyc[1], m0_stall[1], m0_ack[1]}, {3'b010, (k == 8)}); end
        end
        tick(); ack = 1'b0; drive_m(0, 1'b0, 1'b0);
        tick(); tick();
    endtask

    task automatic test_no_timeout();
        int errs_seen;
        int lost;
        errs_seen = 0;
        lost = 0;
        drive_m(0, 1'b1, 1'b1);
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (k >= 1) m0_stb = 1'b0;
            #1;
            if (m0_err[2] !== 1'b0) errs_seen++;
            if (s_cyc[2] !== 1'b1) lost++;
        end
        checks++; if (errs_seen != 0) begin
            errors++; $display("FAIL no_timeout_err: got %0d err cycles expected 0", errs_seen); end
        checks++; if (lost != 0 || m0_stall[2] !== 1'b0) begin
            errors++; $display("FAIL no_timeout_grant_held: got %0d lost cycles stall %b expected 0 0", lost, m0_stall[2]); end
    endtask

    task automatic test_reset_abort();
        rst_n = 1'b0; ack = 1'b1;
        tick(); #1;
        checks++; if ({s_cyc[2], m0_stall[2], m0_ack[2], m0_err[2]} !== 4'b0100) begin
            errors++; $display("FAIL reset_abort: got cyc/stall/ack/err %b expected 0100", {s_cyc[2], m0_stall[2], m0_ack[2], m0_err[2]}); end
        rst_n = 1'b1; ack = 1'b0;
        m0_addr = 32'h1000_0000; m1_addr = 32'h2000_0000;
        drive_m(0, 1'b1, 1'b1);
        drive_m(1, 1'b1, 1'b1);
        tick(); #1;
        checks++; if (s_addr[2] !== 32'h1000_0000 || {m0_stall[2], m1_stall[2]} !== 2'b01) begin
            errors++; $display("FAIL reset_last_tie: got addr %h stalls %b expected 10000000 01", s_addr[2], {m0_stall[2], m1_stall[2]}); end
        drive_m(0, 1'b0, 1'b0);
        drive_m(1, 1'b0, 1'b0);
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_alternation();
        test_back_to_back();
        test_burst();
        test_timeout();
        test_ack_wins();
        test_no_timeout();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/leiwand_rv32_wb_arbiter.md
# leiwand_rv32_wb_arbiter

Two-master Wishbone (pipelined) bus arbiter between the rv32 core's master port(s) and the single shared slave bus (memory/peripherals). Master 0 is instruction fetch and master 1 is load/store, or core plus debug/DMA. Round-robin arbitration, grant held for a whole `cyc` transaction. A per-grant ack timeout returns an error to a master whose slave never responds.

## Interface
Parameters:
- `DATA_WIDTH`, default `MEM_WIDTH` (32): address and data width.
- `TIMEOUT_CYCLES`, default 255: cycles without ack before an error is returned; 0 disables the timeout.

Ports. Clock: one clock. Reset: synchronous, active-low.
- `i_clk`  in  1  clock; all state on rising edge.
- `i_rst_n`  in  1  synchronous active-low reset.
- `i_m0_cyc`, `i_m0_stb`, `i_m0_we`  in  1 each  master 0 Wishbone request.
- `i_m0_addr`, `i_m0_data`  in  DATA_WIDTH  master 0 address and write data.
- `o_m0_ack`, `o_m0_stall`, `o_m0_err`  out  1 each  master 0 responses.
- `o_m0_data`  out  DATA_WIDTH  master 0 read data.
- `i_m1_*` / `o_m1_*`  same set as master 0, for master 1.
- `o_cyc`, `o_stb`, `o_we`  out  1 each  slave-side request.
- `o_addr`, `o_data`  out  DATA_WIDTH  slave-side address and write data.
- `i_ack`, `i_stall`  in  1 each  slave response.
- `i_data`  in  DATA_WIDTH  slave read data.

## Operation
- FSM states: `IDLE`, `GRANT0`, `GRANT1`. Register `last` records the most recently granted master; reset value is 1, so master 0 wins the first tie.
- Transitions out of `IDLE`:
  - If exactly one `i_mX_cyc` is high, go to `GRANTX`.
  - If both are high, go to `GRANT(!last)`.
  - On entering `GRANTX`, set `last <= X`.
- Transitions out of `GRANTX`:
  - Go to `IDLE` when `i_mX_cyc` falls.
  - Go to `IDLE` on timeout.
  - The other master's request never pre-empts the grant.
- Slave-side outputs in `GRANTX`: `o_cyc`, `o_stb`, `o_we`, `o_addr` and `o_data` mux combinationally from master X.
- Slave-side outputs in `IDLE`: all zero.
- Granted master: `o_mX_stall = i_stall`, `o_mX_ack = i_ack`.
- Non-granted master, and both masters in `IDLE`: `o_mX_stall = 1`, `o_mX_ack = 0`, `o_mX_err = 0`.
- Read data: `o_m0_data` and `o_m1_data` both equal `i_data`; only the acked master samples it.
- Timeout counter (width fits `TIMEOUT_CYCLES`):
  - Cleared on entering a grant and on every `i_ack`.
  - Increments each granted cycle without ack, saturating.
  - When the count reaches `TIMEOUT_CYCLES`, the arbiter pulses `o_mX_err` for one cycle, forces `o_cyc`/`o_stb` to 0 that cycle, suppresses `o_mX_ack`, and returns to `IDLE`.
  - The master must drop `cyc` on err.
- If `i_ack` and the timeout coincide, ack wins: the counter clears and no err is raised.
- An ack arriving in `IDLE` is dropped.

## Timing
- Reset (`i_rst_n = 0` at a clock edge) forces:
  - state `IDLE`, `last = 1`, counter = 0;
  - `o_cyc`, `o_stb`, `o_we` = 0; `o_addr`, `o_data` = 0;
  - `o_m0_stall = o_m1_stall = 1`; all ack and err = 0.
- Reset mid-transaction aborts the grant with no ack or err; the master is responsible for its own reset.
- Grant latency:
  - Request seen high in `IDLE` at edge N; `GRANTX` from edge N+1.
  - First slave `o_stb` visible in cycle N+1.
  - The master's `stb` stays stalled until then.
- Release: `i_mX_cyc` low at edge M gives `IDLE` at M+1. One dead cycle always separates two grants, including back-to-back requests from the same master.
- Pipelined bursts: multiple `stb`s within one `cyc` pass through unchanged; `i_stall` is honoured per beat.

## Structure
- Shared package/constants header (alongside `leiwand_rv32_constants.v`):
  - `MEM_WIDTH`
  - FSM state encodings `ARB_IDLE`, `ARB_GRANT0`, `ARB_GRANT1`
  - `HIGH_BIT_TO_FIT`, for sizing the counter
- One natural sub-module: `leiwand_rv32_wb_timeout`. It holds the counter with clear/enable inputs and a one-cycle `o_expired` pulse, and is instantiated once.
- The muxes stay in the top module.

## Test plan
- Reset with both `i_mX_cyc` = 1 → all outputs at reset values. After `i_rst_n` rises: `GRANT0` one cycle later, `o_addr = i_m0_addr` (0x10000000), `o_m1_stall = 1`.
- M0 single read, slave acks 2 cycles after stb with `i_data = 0xDEADBEEF` → `o_m0_ack` for 1 cycle, `o_m0_data = 0xDEADBEEF`. M0 drops cyc → `IDLE` next cycle.
- Both masters request continuously, each doing one-beat transactions → grants alternate M0, M1, M0, M1, with one `IDLE` cycle between each.
- M1 holds cyc for a 4-beat write burst with `i_stall` high on beat 2 → 4 acks to M1, `o_m1_stall` mirrors `i_stall`, M0 stalled throughout.
- `TIMEOUT_CYCLES = 8`, slave never acks → `o_m0_err` pulses exactly 8 granted cycles after grant, `o_cyc = 0` that cycle, then `IDLE`. Repeat with ack in the 8th cycle → ack, no err.
- `TIMEOUT_CYCLES = 0`, no ack for 1000 cycles → no err, grant held.
